// File: rtl/mips_divider_if.sv
`default_nettype none
// ============================================================================
// Module      : mips_divider_if
// Description : Request/response bundle for the multi-cycle EX-stage divider.
//               master : pipeline side (drives the request, reads the result)
//               slave  : divider side
//   start       request a division, sampled only while the divider is idle
//   is_signed   1 = DIV (two's complement), 0 = DIVU
//   dividend    numerator, sampled with start
//   divisor     denominator, sampled with start
//   busy        high while an operation is in progress
//   done        one-cycle pulse when results are valid
//   quotient    result to LO
//   remainder   result to HI
//   div_by_zero set together with done when the divisor was zero
// Revision    : 1.0 - initial release
// ============================================================================
interface mips_divider_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, is_signed, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, is_signed, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface
`default_nettype wire

// File: rtl/mips_divider.sv
`default_nettype none
// ============================================================================
// Module      : mips_divider
// Description : Radix-2 restoring divider for MIPS DIV/DIVU, one quotient bit
//               per clock. Signed operations divide magnitudes and fix the
//               signs in a final cycle. A zero divisor completes in one cycle
//               with quotient all ones and the dividend as remainder.
//   clk    rising-edge clock
//   reset  synchronous, active-high; discards any in-flight operation
//   bus    mips_divider_if.slave (request, busy/done, results)
// Revision    : 1.0 - initial release
// ============================================================================
module mips_divider #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           reset,
  mips_divider_if.slave  bus
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DZ   = 2'd3;

  logic [1:0]       state;
  logic             sgn;        // operation is DIV
  logic             dvd_neg;    // dividend was negative (signed only)
  logic             dvs_neg;    // divisor was negative (signed only)
  logic [WIDTH-1:0] quo;        // dividend magnitude shifting out, quotient shifting in
  logic [WIDTH-1:0] rem;        // partial remainder
  logic [WIDTH-1:0] dvs_mag;
  logic [CW-1:0]    count;

  logic             busy_q;
  logic             done_q;
  logic             dz_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;

  // Operand magnitudes at the request; 0x80000000 negates to itself, which
  // is the correct magnitude when read as unsigned.
  logic             in_dvd_neg;
  logic             in_dvs_neg;
  logic [WIDTH-1:0] in_dvd_mag;
  logic [WIDTH-1:0] in_dvs_mag;

  assign in_dvd_neg = bus.is_signed & bus.dividend[WIDTH-1];
  assign in_dvs_neg = bus.is_signed & bus.divisor[WIDTH-1];
  assign in_dvd_mag = in_dvd_neg ? -bus.dividend : bus.dividend;
  assign in_dvs_mag = in_dvs_neg ? -bus.divisor  : bus.divisor;

  // One restoring step. The shifted remainder is below 2*divisor, so a
  // WIDTH+1-bit difference never wraps: its MSB is a reliable borrow flag.
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;
  logic           borrow;

  assign shifted = {rem, quo[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvs_mag};
  assign borrow  = trial[WIDTH];

  // Sign fix-up. Negating the dividend magnitude recovers the original
  // dividend, which is what the divide-by-zero path reports as remainder.
  logic [WIDTH-1:0] quo_fixed;
  logic [WIDTH-1:0] rem_fixed;
  logic [WIDTH-1:0] dvd_orig;

  assign quo_fixed = (sgn & (dvd_neg ^ dvs_neg)) ? -quo : quo;
  assign rem_fixed = (sgn & dvd_neg) ? -rem : rem;
  assign dvd_orig  = (sgn & dvd_neg) ? -quo : quo;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      sgn         <= 1'b0;
      dvd_neg     <= 1'b0;
      dvs_neg     <= 1'b0;
      quo         <= '0;
      rem         <= '0;
      dvs_mag     <= '0;
      count       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dz_q        <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      // done is a single-cycle pulse unless re-asserted below.
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            sgn     <= bus.is_signed;
            dvd_neg <= in_dvd_neg;
            dvs_neg <= in_dvs_neg;
            quo     <= in_dvd_mag;
            dvs_mag <= in_dvs_mag;
            rem     <= '0;
            count   <= '0;
            busy_q  <= 1'b1;
            state   <= (bus.divisor == '0) ? S_DZ : S_RUN;
          end
        end
        S_RUN: begin
          quo   <= {quo[WIDTH-2:0], ~borrow};
          rem   <= borrow ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
          count <= count + 1'b1;
          if (count == LAST_ITER) begin
            state <= S_FIX;
          end
        end
        S_FIX: begin
          quotient_q  <= quo_fixed;
          remainder_q <= rem_fixed;
          dz_q        <= 1'b0;
          done_q      <= 1'b1;
          busy_q      <= 1'b0;
          state       <= S_IDLE;
        end
        S_DZ: begin
          quotient_q  <= '1;
          remainder_q <= dvd_orig;
          dz_q        <= 1'b1;
          done_q      <= 1'b1;
          busy_q      <= 1'b0;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dz_q;
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_divider
// Description : Directed self-checking bench for mips_divider. Stimulus is
//               applied and outputs are sampled 1 time unit after each
//               rising clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_divider;

  logic clk;
  logic reset;
  int   tests;
  int   failed;
  int   n;
  int   dones;

  mips_divider_if #(.WIDTH(32)) dif ();

  mips_divider #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one request, then wait (bounded) for done; checks latency and results.
  task automatic run_div(input string tag, input logic sg, input logic [31:0] a,
                         input logic [31:0] b, input int lat, input logic [31:0] eq,
                         input logic [31:0] er, input logic edz);
    int k;
    dif.is_signed = sg;
    dif.dividend  = a;
    dif.divisor   = b;
    dif.start     = 1'b1;
    tick();
    dif.start     = 1'b0;
    dif.dividend  = 32'hDEAD_BEEF;   // operands may change after the start edge
    dif.divisor   = 32'h0BAD_F00D;
    dif.is_signed = ~sg;
    chk({tag, " busy"}, {31'd0, dif.busy}, 32'd1);
    k = 0;
    while (dif.done !== 1'b1 && k < 60) begin
      tick();
      k++;
    end
    chk({tag, " latency"}, k, lat);
    chk({tag, " quotient"}, dif.quotient, eq);
    chk({tag, " remainder"}, dif.remainder, er);
    chk({tag, " dz"}, {31'd0, dif.div_by_zero}, {31'd0, edz});
    chk({tag, " busy low"}, {31'd0, dif.busy}, 32'd0);
    tick();
    chk({tag, " done pulse"}, {31'd0, dif.done}, 32'd0);
  endtask

  initial begin
    tests         = 0;
    failed        = 0;
    reset         = 1'b1;
    dif.start     = 1'b0;
    dif.is_signed = 1'b0;
    dif.dividend  = '0;
    dif.divisor   = '0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst busy", {31'd0, dif.busy}, 32'd0);
    chk("rst done", {31'd0, dif.done}, 32'd0);
    chk("rst dz",   {31'd0, dif.div_by_zero}, 32'd0);
    chk("rst q",    dif.quotient, 32'd0);
    chk("rst r",    dif.remainder, 32'd0);
    tick();

    run_div("divu 100/7",   1'b0, 32'd100,        32'd7,          33, 32'd14,        32'd2,        1'b0);
    run_div("div -7/2",     1'b1, 32'hFFFF_FFF9,  32'd2,          33, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    run_div("div 7/-2",     1'b1, 32'd7,          32'hFFFF_FFFE,  33, 32'hFFFF_FFFD, 32'd1,        1'b0);
    run_div("div ovf",      1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  33, 32'h8000_0000, 32'd0,        1'b0);
    run_div("divu ovf ops", 1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  33, 32'd0,         32'h8000_0000, 1'b0);
    run_div("divu max/1",   1'b0, 32'hFFFF_FFFF,  32'd1,          33, 32'hFFFF_FFFF, 32'd0,        1'b0);
    run_div("div by 0",     1'b1, 32'h0000_1234,  32'd0,          1,  32'hFFFF_FFFF, 32'h0000_1234, 1'b1);
    run_div("divu 9/3",     1'b0, 32'd9,          32'd3,          33, 32'd3,         32'd0,        1'b0);
    run_div("div neg by 0", 1'b1, 32'hFFFF_FF00,  32'd0,          1,  32'hFFFF_FFFF, 32'hFFFF_FF00, 1'b1);
    run_div("div -100/-7",  1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  33, 32'd14,        32'hFFFF_FFFE, 1'b0);

    // start while busy is ignored
    dif.is_signed = 1'b0;
    dif.dividend  = 32'd100;
    dif.divisor   = 32'd7;
    dif.start     = 1'b1;
    tick();                                  // edge N
    dif.start = 1'b0;
    for (int i = 0; i < 9; i++) tick();      // edge N+9
    dif.dividend = 32'd50;
    dif.divisor  = 32'd5;
    dif.start    = 1'b1;
    tick();                                  // edge N+10
    dif.start = 1'b0;
    n = 10;
    dones = 0;
    while (dif.done !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    chk("busy-start latency", n, 33);
    chk("busy-start q", dif.quotient, 32'd14);
    chk("busy-start r", dif.remainder, 32'd2);

    // back-to-back: start during the done cycle
    dif.dividend = 32'd50;
    dif.divisor  = 32'd5;
    dif.start    = 1'b1;
    tick();
    dif.start = 1'b0;
    chk("b2b done fell", {31'd0, dif.done}, 32'd0);
    chk("b2b busy rose", {31'd0, dif.busy}, 32'd1);
    n = 0;
    while (dif.done !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    chk("b2b latency", n, 33);
    chk("b2b q", dif.quotient, 32'd10);
    chk("b2b r", dif.remainder, 32'd0);
    tick();

    // reset mid-operation
    dif.dividend = 32'd100;
    dif.divisor  = 32'd7;
    dif.start    = 1'b1;
    tick();                                  // edge N
    dif.start = 1'b0;
    for (int i = 0; i < 14; i++) tick();     // edge N+14
    reset = 1'b1;
    tick();                                  // edge N+15
    reset = 1'b0;
    chk("midrst busy", {31'd0, dif.busy}, 32'd0);
    chk("midrst done", {31'd0, dif.done}, 32'd0);
    chk("midrst q", dif.quotient, 32'd0);
    chk("midrst r", dif.remainder, 32'd0);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (dif.done === 1'b1) dones++;
    end
    chk("midrst no done", dones, 0);

    run_div("divu 20/6", 1'b0, 32'd20, 32'd6, 33, 32'd3, 32'd2, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire
